// File: rtl/i2c_seq_pkg.sv
// Shared constants for the I2C register-transfer sequencer: core register map, CR/SR bit
// positions, response codes and the sequencer state encoding.
package i2c_seq_pkg;

  localparam logic [2:0] RegPrerLo = 3'd0;
  localparam logic [2:0] RegPrerHi = 3'd1;
  localparam logic [2:0] RegCtr    = 3'd2;
  localparam logic [2:0] RegTxRx   = 3'd3;
  localparam logic [2:0] RegCrSr   = 3'd4;

  localparam int unsigned CrSta = 7;
  localparam int unsigned CrSto = 6;
  localparam int unsigned CrRd  = 5;
  localparam int unsigned CrWr  = 4;
  localparam int unsigned CrAck = 3;

  localparam int unsigned SrRxAck = 7;
  localparam int unsigned SrAl    = 5;
  localparam int unsigned SrTip   = 1;

  localparam logic [1:0] ErrOk      = 2'd0;
  localparam logic [1:0] ErrNack    = 2'd1;
  localparam logic [1:0] ErrArb     = 2'd2;
  localparam logic [1:0] ErrTimeout = 2'd3;

  localparam logic [7:0] CtrCoreEn = 8'h80;
  localparam int unsigned TimeoutW = 20;

  // Transfer phases: address byte, register byte, third byte (data or re-address), read byte
  localparam logic [1:0] PhAddr  = 2'd0;
  localparam logic [1:0] PhReg   = 2'd1;
  localparam logic [1:0] PhThird = 2'd2;
  localparam logic [1:0] PhRead  = 2'd3;

  typedef enum logic [3:0] {
    StInitPrl,
    StInitPrh,
    StInitCtr,
    StIdle,
    StTxr,
    StCr,
    StPollReq,
    StPollWait,
    StStop,
    StRxReq,
    StRxWait,
    StResp
  } state_e;

  function automatic logic [7:0] cr_byte(input logic sta, input logic sto, input logic rd,
                                         input logic wr, input logic ack);
    logic [7:0] r;
    r        = '0;
    r[CrSta] = sta;
    r[CrSto] = sto;
    r[CrRd]  = rd;
    r[CrWr]  = wr;
    r[CrAck] = ack;
    return r;
  endfunction

endpackage

// File: rtl/i2c_reg_port.sv
// Read side of the I2C core register port: one-cycle read strobe, then the byte is
// captured RdLat cycles later and handed back with a one-cycle done pulse.
module i2c_reg_port
  import i2c_seq_pkg::*;
#(
  parameter int unsigned RdLat = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start_i,
  input  logic [2:0] addr_i,
  output logic       ip_rx_en_o,
  output logic [2:0] ip_raddr_o,
  input  logic [7:0] ip_rdata_i,
  output logic       done_o,
  output logic [7:0] data_o
);

  logic       busy_q, busy_d;
  logic [7:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic [7:0] data_q, data_d;

  assign ip_rx_en_o = start_i;
  assign ip_raddr_o = start_i ? addr_i : 3'd0;
  assign done_o     = done_q;
  assign data_o     = data_q;

  // cnt_q counts down to the cycle in which the core's read data is valid
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    data_d = data_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = 8'(RdLat - 1);
    end else if (busy_q) begin
      if (cnt_q == 8'd0) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        data_d = ip_rdata_i;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q <= 1'b0;
      cnt_q  <= 8'd0;
      done_q <= 1'b0;
      data_q <= 8'd0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/i2c_xfer_seq.sv
// Sequences single-byte I2C register reads/writes through a byte-wide I2C core register port.
// Define I2C_XFER_SEQ_TIMEOUT_EN to bound status polling with a 20-bit timeout.
module i2c_xfer_seq
  import i2c_seq_pkg::*;
#(
  parameter logic [15:0] PRESCALE = 16'd199,
  parameter int unsigned RD_LAT   = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_rw_i,
  input  logic [6:0] cmd_dev_i,
  input  logic [7:0] cmd_reg_i,
  input  logic [7:0] cmd_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic [1:0] rsp_err_o,
  output logic       ip_tx_en_o,
  output logic [2:0] ip_waddr_o,
  output logic [7:0] ip_wdata_o,
  output logic       ip_rx_en_o,
  output logic [2:0] ip_raddr_o,
  input  logic [7:0] ip_rdata_i
);

  state_e     state_q, state_d;
  logic       run_q;
  logic       rw_q, rw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wdata_q, wdata_d;
  logic [1:0] phase_q, phase_d;
  logic       stop_q, stop_d;
  logic [1:0] err_q, err_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0] rsp_err_q, rsp_err_d;

  logic       port_start;
  logic [2:0] port_addr;
  logic       port_done;
  logic [7:0] port_data;
  logic [7:0] txr_val;
  logic [7:0] cr_val;

`ifdef I2C_XFER_SEQ_TIMEOUT_EN
  logic [TimeoutW-1:0] to_cnt_q, to_cnt_d;
  logic                in_poll;
  assign in_poll = (state_q == StPollReq) || (state_q == StPollWait);
`endif

  i2c_reg_port #(
    .RdLat (RD_LAT)
  ) u_reg_port (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (port_start),
    .addr_i     (port_addr),
    .ip_rx_en_o (ip_rx_en_o),
    .ip_raddr_o (ip_raddr_o),
    .ip_rdata_i (ip_rdata_i),
    .done_o     (port_done),
    .data_o     (port_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StInitPrl;
      run_q       <= 1'b0;
      rw_q        <= 1'b0;
      dev_q       <= 7'd0;
      reg_q       <= 8'd0;
      wdata_q     <= 8'd0;
      phase_q     <= PhAddr;
      stop_q      <= 1'b0;
      err_q       <= ErrOk;
      rdata_q     <= 8'd0;
      rsp_rdata_q <= 8'd0;
      rsp_err_q   <= ErrOk;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      rw_q        <= rw_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      phase_q     <= phase_d;
      stop_q      <= stop_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef I2C_XFER_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    phase_d     = phase_q;
    stop_d      = stop_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StInitPrl: if (run_q) state_d = StInitPrh;
      StInitPrh: state_d = StInitCtr;
      StInitCtr: state_d = StIdle;
      StIdle: begin
        if (cmd_valid_i) begin
          rw_d    = cmd_rw_i;
          dev_d   = cmd_dev_i;
          reg_d   = cmd_reg_i;
          wdata_d = cmd_wdata_i;
          phase_d = PhAddr;
          stop_d  = 1'b0;
          err_d   = ErrOk;
          rdata_d = 8'd0;
          state_d = StTxr;
        end
      end
      StTxr:     state_d = StCr;
      StCr:      state_d = StPollReq;
      StPollReq: state_d = StPollWait;
      StPollWait: begin
        if (port_done) begin
          // Arbitration loss outranks NACK; the STOP poll after a NACK only waits for TIP
          if (port_data[SrTip]) begin
            state_d = StPollReq;
          end else if (stop_q) begin
            state_d = StResp;
          end else if (port_data[SrAl]) begin
            err_d   = ErrArb;
            state_d = StResp;
          end else if (phase_q != PhRead && port_data[SrRxAck]) begin
            err_d   = ErrNack;
            state_d = StStop;
          end else if (phase_q == PhThird && !rw_q) begin
            state_d = StResp;
          end else if (phase_q == PhThird) begin
            phase_d = PhRead;
            state_d = StCr;
          end else if (phase_q == PhRead) begin
            state_d = StRxReq;
          end else begin
            phase_d = phase_q + 2'd1;
            state_d = StTxr;
          end
        end
      end
      StStop: begin
        if (err_q == ErrTimeout) begin
          state_d = StResp;
        end else begin
          stop_d  = 1'b1;
          state_d = StPollReq;
        end
      end
      StRxReq: state_d = StRxWait;
      StRxWait: begin
        if (port_done) begin
          rdata_d = port_data;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StInitPrl;
    endcase

`ifdef I2C_XFER_SEQ_TIMEOUT_EN
    to_cnt_d = in_poll ? to_cnt_q + 1'b1 : '0;
    if (in_poll && (to_cnt_q == '1)) begin
      err_d   = ErrTimeout;
      rdata_d = 8'd0;
      state_d = StStop;
    end
`endif

    if (state_d == StResp && state_q != StResp) begin
      rsp_err_d   = err_d;
      rsp_rdata_d = rdata_d;
    end
  end

  always_comb begin
    txr_val = 8'd0;
    cr_val  = 8'd0;
    case (phase_q)
      PhAddr: begin
        txr_val = {dev_q, 1'b0};
        cr_val  = cr_byte(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      PhReg: begin
        txr_val = reg_q;
        cr_val  = cr_byte(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      PhThird: begin
        txr_val = rw_q ? {dev_q, 1'b1} : wdata_q;
        cr_val  = cr_byte(rw_q, !rw_q, 1'b0, 1'b1, 1'b0);
      end
      default: cr_val = cr_byte(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    endcase
  end

  always_comb begin
    ip_tx_en_o  = 1'b0;
    ip_waddr_o  = 3'd0;
    ip_wdata_o  = 8'd0;
    port_start  = 1'b0;
    port_addr   = RegCrSr;
    rsp_valid_o = 1'b0;
    unique case (state_q)
      StInitPrl: begin
        ip_tx_en_o = run_q;
        ip_waddr_o = run_q ? RegPrerLo : 3'd0;
        ip_wdata_o = run_q ? PRESCALE[7:0] : 8'd0;
      end
      StInitPrh: begin
        ip_tx_en_o = 1'b1;
        ip_waddr_o = RegPrerHi;
        ip_wdata_o = PRESCALE[15:8];
      end
      StInitCtr: begin
        ip_tx_en_o = 1'b1;
        ip_waddr_o = RegCtr;
        ip_wdata_o = CtrCoreEn;
      end
      StTxr: begin
        ip_tx_en_o = 1'b1;
        ip_waddr_o = RegTxRx;
        ip_wdata_o = txr_val;
      end
      StCr: begin
        ip_tx_en_o = 1'b1;
        ip_waddr_o = RegCrSr;
        ip_wdata_o = cr_val;
      end
      StStop: begin
        ip_tx_en_o = 1'b1;
        ip_waddr_o = RegCrSr;
        ip_wdata_o = cr_byte(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      StPollReq: port_start = 1'b1;
      StRxReq: begin
        port_start = 1'b1;
        port_addr  = RegTxRx;
      end
      StResp:  rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: doc/i2c_xfer_seq.md
I2C_XFER_SEQ -- requirements
Module: i2c_xfer_seq

Interface
REQ-001 Parameter PRESCALE, default 16'd199: SCL prescaler value written to the I2C core at init (e.g. 100 kHz at 100 MHz).
REQ-002 Parameter RD_LAT, default 3: cycles from ip_rx_en pulse to valid ip_rdata.
REQ-003 clk  input  1  clock; all logic on posedge clk.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-007 cmd_rw  input  1  0=register write, 1=register read.
REQ-008 cmd_dev  input  7  7-bit slave address.
REQ-009 cmd_reg  input  8  slave register index.
REQ-010 cmd_wdata  input  8  write byte (ignored for reads).
REQ-011 rsp_valid  output  1  one-cycle pulse, transaction finished.
REQ-012 rsp_rdata  output  8  read byte; 0 for writes or errors.
REQ-013 rsp_err  output  2  0=ok, 1=NACK, 2=arbitration lost, 3=timeout.
REQ-014 ip_tx_en / ip_waddr / ip_wdata  output  1/3/8  I2C core register write port.
REQ-015 ip_rx_en / ip_raddr  output  1/3  I2C core register read strobe (single-cycle pulse).
REQ-016 ip_rdata  input  8  core read data, valid RD_LAT cycles after ip_rx_en.

Function
REQ-017 Core registers: 0 PRERlo, 1 PRERhi, 2 CTR, 3 TXR/RXR, 4 CR/SR. CR bits: STA=7, STO=6, RD=5, WR=4, ACK=3. SR bits: RxACK=7, AL=5, TIP=1.
REQ-018 After reset: INIT_PRL (PRESCALE[7:0]) -> INIT_PRH (PRESCALE[15:8]) -> INIT_CTR (0x80), one ip_tx_en pulse each on consecutive cycles -> IDLE.
REQ-019 cmd_ready=1 only in IDLE; the command is latched on acceptance; cmd_* is ignored until IDLE.
REQ-020 Write sequence: TXR={dev,0}, CR=STA|WR, POLL; TXR=reg, CR=WR, POLL; TXR=wdata, CR=STO|WR, POLL; RESP.
REQ-021 Read sequence: TXR={dev,0}, CR=STA|WR, POLL; TXR=reg, CR=WR, POLL; TXR={dev,1}, CR=STA|WR, POLL; CR=RD|ACK|STO, POLL; read RXR; RESP.
REQ-022 POLL: pulse ip_rx_en at raddr=4, wait RD_LAT cycles, sample SR; if TIP=1, repeat; else evaluate.
REQ-023 Evaluation precedence: AL=1 -> err 2, go RESP directly with no STOP; RxACK=1 after any write phase -> err 1, issue CR=STO, POLL, then RESP.
REQ-024 ip_tx_en and ip_rx_en are never asserted in the same cycle; at most one strobe per cycle.
REQ-025 RESP: rsp_valid high exactly one cycle, then IDLE; rsp_rdata/rsp_err hold until the next rsp_valid.

Reset
REQ-026 In reset, all outputs are 0 except cmd_ready, which is also 0.
REQ-027 In reset, the FSM is in INIT_PRL and the latched command is cleared.
REQ-028 Reset mid-transaction aborts the transaction without rsp_valid and re-runs init.

Configuration
REQ-029 With macro I2C_XFER_SEQ_TIMEOUT_EN defined: a 20-bit counter clears on entering POLL and increments each POLL cycle.
REQ-030 With I2C_XFER_SEQ_TIMEOUT_EN, reaching 2^20-1 forces CR=STO and RESP with err 3.
REQ-031 Without I2C_XFER_SEQ_TIMEOUT_EN, there is no counter and POLL waits indefinitely.

Structure
REQ-032 Package i2c_seq_pkg holds the register address constants, CR/SR bit indices, rsp_err codes, and the FSM state enum.
REQ-033 Sub-module i2c_reg_port handles the read strobe and RD_LAT delay, and returns a sampled-byte pulse to the FSM.

Verification
REQ-034 Reset release -> writes (0,0xC7),(1,0x00),(2,0x80) on three consecutive cycles; cmd_ready rises after them.
REQ-035 Write dev=0x50, reg=0x10, data=0xA5, slave model ACKs -> TXR writes 0xA0,0x10,0xA5; last CR=0x50; rsp_err=0.
REQ-036 Read dev=0x50, reg=0x20, model returns 0x3C -> TXR 0xA0,0x20,0xA1; final CR=0x68; rsp_rdata=0x3C, err=0.
REQ-037 SR returns RxACK=1 after the address byte -> CR=0x40 is written; rsp_err=1; rsp_rdata=0.
REQ-038 SR returns AL=1 -> no STO write; rsp_err=2 on the next RESP.
REQ-039 With the timeout macro defined, TIP held at 1 -> rsp_err=3 after 2^20-1 POLL cycles; without the macro, no rsp_valid.
